// File: rtl/led_pattern_sched_pkg.sv
// rtl/led_pattern_sched_pkg.sv - shared types and round-robin pick for the LED scheduler
// Package led_sched_pkg:
//   state_t     scheduler FSM states
//   IDLE_LED0/1 LED levels shown whenever no pattern is playing
//   rr_pick     first set request bit at or after ptr, wrapping modulo num_req
package led_sched_pkg;

  typedef enum logic [1:0] {IDLE, ALIGN, PLAY, DONE} state_t;

  localparam logic IDLE_LED0 = 1'b0;
  localparam logic IDLE_LED1 = 1'b1;

  // Upper bound on requesters; callers zero-extend their request vector.
  localparam int MAX_REQ   = 8;
  localparam int MAX_PTR_W = 3;

  typedef struct packed {
    logic                 valid;
    logic [MAX_PTR_W-1:0] idx;
  } rr_pick_t;

  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                       input int ptr,
                                       input int num_req);
    rr_pick_t r;
    int k;
    r.valid = 1'b0;
    r.idx   = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (i < num_req) begin
        // Explicit wrap so non-power-of-two requester counts work.
        k = ptr + i;
        if (k >= num_req) k = k - num_req;
        if (!r.valid && req[k]) begin
          r.valid = 1'b1;
          r.idx   = MAX_PTR_W'(k);
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/led_pattern_sched_if.sv
// rtl/led_pattern_sched_if.sv - request/grant bundle between LED sources and the scheduler
// Signals:
//   req  [NUM_REQ]          per-requester request level, held until done
//   pat0 [NUM_REQ*PAT_LEN]  led0 patterns, requester i at [i*PAT_LEN +: PAT_LEN]
//   pat1 [NUM_REQ*PAT_LEN]  led1 patterns, same packing
//   gnt  [NUM_REQ]          one-hot grant, zero when idle
//   done [NUM_REQ]          one-cycle one-hot completion pulse
//   busy                    high while any grant is active
// Modports: master = requester side, slave = scheduler side.
interface led_pattern_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int PAT_LEN = 8
);
  logic [NUM_REQ-1:0]         req;
  logic [NUM_REQ*PAT_LEN-1:0] pat0;
  logic [NUM_REQ*PAT_LEN-1:0] pat1;
  logic [NUM_REQ-1:0]         gnt;
  logic [NUM_REQ-1:0]         done;
  logic                       busy;

  modport master (output req, pat0, pat1, input gnt, done, busy);
  modport slave  (input req, pat0, pat1, output gnt, done, busy);
endinterface

// File: rtl/led_pattern_sched_tick_gen.sv
// rtl/led_pattern_sched_tick_gen.sv - free-running prescaler producing a one-cycle tick
// Module led_tick_gen:
//   clk    system clock
//   reset  synchronous active-high reset (counter back to 0)
//   tick   high for one cycle when the count reaches TICK_DIV-1
module led_tick_gen #(
  parameter int TICK_DIV = 24_000_000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);
  localparam int              CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset)            cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == LAST);
endmodule

// File: rtl/led_pattern_sched.sv
// rtl/led_pattern_sched.sv - round-robin scheduler sharing two LEDs between requesters
// Ports:
//   clk    system clock
//   reset  synchronous active-high reset
//   sif    led_pattern_sched_if.slave (req, pat0, pat1 in; gnt, done, busy out)
//   led0   LED 0 drive (registered)
//   led1   LED 1 drive (registered)
// The granted requester's patterns are copied into shift registers at grant and
// played LSB first, one bit per prescaler tick.
module led_pattern_sched
  import led_sched_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int PAT_LEN  = 8,
  parameter int TICK_DIV = 24_000_000
) (
  input  logic                clk,
  input  logic                reset,
  led_pattern_sched_if.slave  sif,
  output logic                led0,
  output logic                led1
);
  localparam int               PTR_W    = $clog2(NUM_REQ);
  localparam int               IDX_W    = $clog2(PAT_LEN + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);
  localparam logic [IDX_W-1:0] IDX_END  = IDX_W'(PAT_LEN);

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d, sel_q, sel_d, ptr_next, pick_sel;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [PAT_LEN-1:0] sh0_q, sh0_d, sh1_q, sh1_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d, done_q, done_d;
  logic               busy_q, busy_d, led0_q, led0_d, led1_q, led1_d;
  logic               tick;
  rr_pick_t           pick;

  led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  assign pick     = rr_pick(MAX_REQ'(sif.req), int'(ptr_q), NUM_REQ);
  assign pick_sel = PTR_W'(pick.idx);
  assign ptr_next = (sel_q == PTR_LAST) ? '0 : sel_q + 1'b1;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    idx_d   = idx_q;
    sh0_d   = sh0_q;
    sh1_d   = sh1_q;
    gnt_d   = gnt_q;
    busy_d  = busy_q;
    done_d  = '0;
    led0_d  = led0_q;
    led1_d  = led1_q;

    case (state_q)
      IDLE: begin
        led0_d = IDLE_LED0;
        led1_d = IDLE_LED1;
        if (pick.valid) begin
          sel_d           = pick_sel;
          sh0_d           = sif.pat0[int'(pick_sel)*PAT_LEN +: PAT_LEN];
          sh1_d           = sif.pat1[int'(pick_sel)*PAT_LEN +: PAT_LEN];
          gnt_d           = '0;
          gnt_d[pick_sel] = 1'b1;
          busy_d          = 1'b1;
          state_d         = ALIGN;
        end
      end

      ALIGN, PLAY: begin
        if (!sif.req[sel_q]) begin
          // Requester withdrew: release silently, still rotate past it.
          state_d = IDLE;
          gnt_d   = '0;
          busy_d  = 1'b0;
          led0_d  = IDLE_LED0;
          led1_d  = IDLE_LED1;
          ptr_d   = ptr_next;
        end else if (tick) begin
          if (state_q == PLAY && idx_q == IDX_END) begin
            state_d       = DONE;
            gnt_d         = '0;
            busy_d        = 1'b0;
            done_d[sel_q] = 1'b1;
            led0_d        = IDLE_LED0;
            led1_d        = IDLE_LED1;
          end else begin
            // Shadows shift right each step, so bit 0 is always the next bit.
            led0_d  = sh0_q[0];
            led1_d  = sh1_q[0];
            sh0_d   = sh0_q >> 1;
            sh1_d   = sh1_q >> 1;
            idx_d   = (state_q == ALIGN) ? IDX_W'(1) : idx_q + 1'b1;
            state_d = PLAY;
          end
        end
      end

      DONE: begin
        ptr_d   = ptr_next;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      idx_q   <= '0;
      sh0_q   <= '0;
      sh1_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      led0_q  <= IDLE_LED0;
      led1_q  <= IDLE_LED1;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      idx_q   <= idx_d;
      sh0_q   <= sh0_d;
      sh1_q   <= sh1_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      led0_q  <= led0_d;
      led1_q  <= led1_d;
    end
  end

  assign sif.gnt  = gnt_q;
  assign sif.done = done_q;
  assign sif.busy = busy_q;
  assign led0     = led0_q;
  assign led1     = led1_q;
endmodule

// File: tb/tb_led_pattern_sched.sv
// tb/tb_led_pattern_sched.sv - directed self-checking bench for led_pattern_sched
module tb_led_pattern_sched;
  localparam int NR = 4;
  localparam int PL = 8;
  localparam int TD = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic led0, led1;
  logic mon_en = 1'b0;
  int   n_chk  = 0;
  int   n_pass = 0;

  led_pattern_sched_if #(.NUM_REQ(NR), .PAT_LEN(PL)) sif ();

  led_pattern_sched #(.NUM_REQ(NR), .PAT_LEN(PL), .TICK_DIV(TD)) dut (
    .clk   (clk),
    .reset (reset),
    .sif   (sif),
    .led0  (led0),
    .led1  (led1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // gnt onehot0, done onehot0, done&gnt==0, busy==|gnt
  always @(negedge clk) begin
    if (mon_en && !reset)
      chk("invariants",
          {$onehot0(sif.gnt), $onehot0(sif.done),
           ((sif.done & sif.gnt) == '0), (sif.busy == (|sif.gnt))}, 4'hF);
  end

  task automatic do_reset();
    reset    = 1'b1;
    sif.req  = '0;
    repeat (3) @(negedge clk);
    reset    = 1'b0;
  endtask

  // Called at the grant negedge (ALIGN, idle LEDs); returns at the first bit.
  task automatic wait_first(input string tag);
    int n = 0;
    while ({led0, led1} == 2'b01 && n < 2*TD) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_align_len"}, (n >= 1 && n <= TD), 1);
  endtask

  task automatic check_bits(input string tag, input logic [3:0] gexp,
                            input logic [7:0] p0, input logic [7:0] p1,
                            input int nbits, input bit mut);
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < TD; c++) begin
        if (mut && b == 2 && c == 0) sif.pat0[0 +: PL] = ~p0;
        chk({tag, "_bit"}, {sif.gnt, led0, led1}, {gexp, p0[b], p1[b]});
        @(negedge clk);
      end
    end
  endtask

  initial begin
    int quiet;
    int n;
    int m;
    int exp_order[6];
    exp_order = '{0, 1, 3, 0, 1, 3};
    sif.req  = '0;
    sif.pat0 = '0;
    sif.pat1 = '0;

    // Reset and idle
    do_reset();
    chk("rst_outputs", {sif.gnt, sif.busy, sif.done, led0, led1},
        {4'b0, 1'b0, 4'b0, 1'b0, 1'b1});
    mon_en = 1'b1;
    quiet  = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sif.done != '0 || sif.gnt != '0 || {led0, led1} != 2'b01) quiet++;
    end
    chk("idle_quiet", quiet, 0);

    // Single play on requester 2
    do_reset();
    sif.pat0[2*PL +: PL] = 8'b1010_0110;
    sif.pat1[2*PL +: PL] = 8'hF0;
    sif.req = 4'b0100;
    @(negedge clk);
    chk("play_gnt", {sif.gnt, sif.busy}, {4'b0100, 1'b1});
    wait_first("play");
    check_bits("play", 4'b0100, 8'b1010_0110, 8'hF0, 8, 1'b0);
    chk("play_done", {sif.done, sif.gnt, sif.busy, led0, led1},
        {4'b0100, 4'b0, 1'b0, 1'b0, 1'b1});
    sif.req = '0;
    @(negedge clk);
    chk("play_done_pulse", sif.done, 0);

    // Round robin with 0,1,3 requesting continuously
    do_reset();
    sif.pat0 = 32'h5A3C_96E1;
    sif.pat1 = '0;
    sif.req  = 4'b1011;
    for (int k = 0; k < 6; k++) begin
      n = 0;
      while (sif.gnt == '0 && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("rr_gnt", sif.gnt, 32'(1) << exp_order[k]);
      if (k > 0) chk("rr_gap", (n >= 2), 1);
      m = 0;
      while (sif.done == '0 && m < 60) begin
        @(negedge clk);
        m++;
      end
      chk("rr_done", sif.done, 32'(1) << exp_order[k]);
    end
    sif.req = '0;

    // Abort after two steps; pending requester 3 follows
    do_reset();
    sif.pat0 = '0;
    sif.pat1 = '0;
    sif.pat0[1*PL +: PL] = 8'h5A;
    sif.req = 4'b1010;
    @(negedge clk);
    chk("abort_gnt", sif.gnt, 4'b0010);
    wait_first("abort");
    check_bits("abort", 4'b0010, 8'h5A, 8'h00, 1, 1'b0);
    chk("abort_bit1", {sif.gnt, led0, led1}, {4'b0010, 1'b1, 1'b0});
    sif.req = 4'b1000;
    @(negedge clk);
    chk("abort_idle", {sif.gnt, sif.busy, sif.done, led0, led1},
        {4'b0, 1'b0, 4'b0, 1'b0, 1'b1});
    @(negedge clk);
    chk("abort_next_gnt", {sif.gnt, sif.done}, {4'b1000, 4'b0});
    sif.req = '0;

    // Pattern latched at grant; input changes mid-play are ignored
    do_reset();
    sif.pat0 = '0;
    sif.pat1 = '0;
    sif.pat0[0 +: PL] = 8'h3C;
    sif.pat1[0 +: PL] = 8'hAA;
    sif.req = 4'b0001;
    @(negedge clk);
    chk("latch_gnt", sif.gnt, 4'b0001);
    wait_first("latch");
    check_bits("latch", 4'b0001, 8'h3C, 8'hAA, 8, 1'b1);
    chk("latch_done", sif.done, 4'b0001);
    sif.req = '0;

    // Reset during step 5 of a play
    do_reset();
    sif.pat0 = '0;
    sif.pat1 = '0;
    sif.pat0[2*PL +: PL] = 8'b1010_0110;
    sif.pat1[2*PL +: PL] = 8'hF0;
    sif.req = 4'b0100;
    @(negedge clk);
    chk("mid_gnt", sif.gnt, 4'b0100);
    wait_first("mid");
    check_bits("mid", 4'b0100, 8'b1010_0110, 8'hF0, 4, 1'b0);
    chk("mid_step5", {sif.gnt, sif.busy}, {4'b0100, 1'b1});
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst", {sif.gnt, sif.busy, sif.done, led0, led1},
        {4'b0, 1'b0, 4'b0, 1'b0, 1'b1});
    reset   = 1'b0;
    sif.req = 4'b1111;
    @(negedge clk);
    chk("mid_ptr0", sif.gnt, 4'b0001);
    sif.req = '0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit (checks %0d/%0d)", n_pass, n_chk);
    $fatal(1);
  end
endmodule

// File: doc/led_pattern_sched.md
Name: led_pattern_sched

Overview:
- Round-robin scheduler that shares the two board LEDs (led0, led1) between NUM_REQ requesters.
- Each requester submits a pair of PAT_LEN-bit blink patterns; the winner's patterns are played out one bit per prescaler tick, then the LEDs are released to the next requester.
- Sits between status/debug sources (PLL lock, error flags, heartbeat) and the LED pins; replaces a hard-wired blinker.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- PAT_LEN, 8, pattern length in ticks (bits per LED).
- TICK_DIV, 24_000_000, clk cycles per pattern step (>=2).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  per-requester request level; hold high until done.
- pat0  input  NUM_REQ*PAT_LEN  led0 patterns; requester i at [i*PAT_LEN +: PAT_LEN].
- pat1  input  NUM_REQ*PAT_LEN  led1 patterns; same packing.
- gnt  output  NUM_REQ  one-hot grant; all-zero when idle.
- done  output  NUM_REQ  one-cycle one-hot pulse when a pattern completes.
- busy  output  1  high while any grant is active.
- led0  output  1  LED 0 drive.
- led1  output  1  LED 1 drive.

Behaviour:
- All outputs are registered. Reset: gnt=0, done=0, busy=0, led0=0, led1=1 (idle pattern), rr pointer=0, prescaler=0, state=IDLE.
- Prescaler runs free from reset: counts 0..TICK_DIV-1 and wraps. tick is an internal 1-cycle pulse when count==TICK_DIV-1. It is not restarted by grants.
- FSM states: IDLE, ALIGN, PLAY, DONE.
- IDLE:
  - led0=0, led1=1.
  - If any req bit is high, pick the first set bit searching from ptr, ptr+1, ... modulo NUM_REQ.
  - Latch that requester's pat0/pat1 slices into shadow registers, set gnt one-hot and busy=1, and go to ALIGN. gnt is visible the cycle after req is sampled.
  - Pattern inputs are sampled only at grant; later changes are ignored.
- ALIGN:
  - LEDs hold the idle pattern.
  - On tick, drive led0=shadow0[0] and led1=shadow1[0], set idx=1, and go to PLAY.
- PLAY:
  - On each tick with idx<PAT_LEN, drive bit idx (LSB first) and increment idx.
  - On the tick with idx==PAT_LEN, go to DONE. The last bit is therefore held for a full tick period.
- DONE (1 cycle):
  - done[granted]=1; gnt=0, busy=0; LEDs return to the idle pattern.
  - ptr=granted+1 mod NUM_REQ; go to IDLE.
  - The earliest next gnt is the cycle after IDLE is re-entered, so there is a 2-cycle gap minimum.
- Abort: if req[granted] is low in ALIGN or PLAY, the next cycle is IDLE. gnt=0, busy=0, idle LEDs, no done pulse; ptr advances as for DONE.
- Simultaneous requests: strict round robin, so no requester waits more than NUM_REQ-1 full patterns.
- A requester that keeps req high after done is re-queued. It is granted again only after every other pending requester has been served.
- Requests from non-granted requesters have no effect until IDLE.
- reset asserted in any state forces the reset values on the next clk edge. Pattern and prescaler state are discarded.
- Widths:
  - Prescaler width is $clog2(TICK_DIV).
  - idx width is $clog2(PAT_LEN+1).
  - ptr width is $clog2(NUM_REQ); wrap is explicit, not reliant on power-of-two overflow.
- Invariants (assert in bench): gnt is onehot0; done is onehot0; done&gnt==0; busy==|gnt.

Decomposition:
- Package led_sched_pkg: state enum (IDLE, ALIGN, PLAY, DONE), IDLE_LED0=0, IDLE_LED1=1, and a round-robin pick function (req vector, ptr) -> index/valid.
- Sub-module led_tick_gen (parameter TICK_DIV; ports clk, reset, tick) isolates the prescaler and is reusable for other timed blocks.

Test Plan (TICK_DIV=4, PAT_LEN=8, NUM_REQ=4):
- Reset/idle: hold reset 3 cycles, no req -> led0=0, led1=1, gnt=0, busy=0, done never pulses over 100 cycles.
- Single play: req[2]=1, pat0[2]=8'b1010_0110, pat1[2]=8'hF0 -> gnt=4'b0100 one cycle later. From first tick, led0 shows 0,1,1,0,0,1,0,1 and led1 shows 0,0,0,0,1,1,1,1, each held 4 cycles. Then done=4'b0100 for one cycle, LEDs return to 0/1.
- Round robin: req=4'b1011 held continuously -> grant order 0,1,3,0,1,3. Each done precedes the next gnt by >=2 cycles.
- Abort: req[1] granted and dropped after 2 pattern steps -> gnt=0 the next cycle, idle LEDs, no done pulse. Pending req[3] is granted next.
- Pattern latch: change pat0[0] during PLAY -> output continues the originally latched pattern bit-for-bit.
- Mid-play reset: assert reset during PLAY step 5 -> next edge shows gnt=0, led0=0, led1=1, ptr=0. After release, req=4'b1111 grants requester 0 first.
